round_sequencer: RTL and testbench
==================================

# round_sequencer

Upstream stage of the rock-paper-scissors scorer. Turns the raw, bouncing load switch into exactly one clean round per press. Captures the user's move and the computer generator's move in the same cycle and presents them, with a single-cycle `play` strobe, to the scoring logic. Rejects the unused move code, counts valid rounds, and blocks re-triggering until the switch is released.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive cycles a synchronized input must differ from the stable value before it is accepted (10 ms at 50 MHz); minimum 1.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width.
- `clock` input 1: single clock (CLOCK_50 at top); all state changes on its rising edge.
- `reset` input 1: synchronous, active-low (KEY[0] at top).
- `load_sw` input 1: raw asynchronous load switch (SW[9]).
- `user_sw` input 2: raw user move (SW[1:0]); 00 rock, 01 scissor, 10 paper, 11 invalid.
- `com_choice` input 2: free-running computer move from the generator; always 00/01/10.
- `play` output 1: one-cycle strobe; the registered moves are a valid round.
- `invalid` output 1: one-cycle strobe; the press was rejected because `user_move` is 11.
- `user_move` output 2: user move latched at round start.
- `com_move` output 2: computer move latched in the same cycle.
- `round_count` output 8: number of valid rounds, modulo 256.
- `busy` output 1: high while in HOLD.

## Operation
- Sync: two-flop synchronizer on `load_sw`. `user_sw` is quasi-static and is sampled directly at capture.
- Debounce:
  - `stable` register resets to 0.
  - Counter increments while the synchronized value differs from `stable` and clears when they are equal.
  - When the counter equals `DEBOUNCE_CYCLES-1` and the values still differ: `stable` toggles and the counter clears.
  - Glitches shorter than `DEBOUNCE_CYCLES` cycles are never accepted.
- Edge detect: `rise` = `stable` & ~`stable_d`; `fall` = ~`stable` & `stable_d`.
- FSM states:
  - IDLE (reset state): on `rise`, capture and go to HOLD.
  - HOLD: on `fall`, go to IDLE; `rise` is impossible in this state.
- Capture, on the IDLE→HOLD edge:
  - `user_move` <= `user_sw`; `com_move` <= `com_choice`.
  - If `user_sw` != 11: `play` <= 1 and `round_count` <= `round_count`+1 (8-bit wrap, 255→0).
  - Otherwise: `invalid` <= 1, and `round_count` is unchanged.
- Strobes: `play` and `invalid` are cleared on every other edge, are never high together, and each is high for exactly one cycle per press.
- Outputs: `user_move` and `com_move` hold their values until the next capture.
- Reset (low at an edge) clears everything regardless of state, including mid-debounce and mid-HOLD:
  - all outputs go to 0;
  - sync flops, `stable`, `stable_d` and the counter clear;
  - state goes to IDLE.
- A switch held high through reset release is debounced again and produces exactly one new round.

## Timing
- Reset values: `play`=0, `invalid`=0, `user_move`=00, `com_move`=00, `round_count`=0, `busy`=0.
- Latency: number as edge 1 the first edge that samples `load_sw`=1.
  - `stable` rises at edge D+2 (D = `DEBOUNCE_CYCLES`).
  - `play` (or `invalid`) and the captured moves are visible after edge D+3.
  - `busy` rises at the same edge.
- Release: `busy` falls D+3 edges after the first low sample, by the same counting.
- Minimum round period: 2·(D+3) cycles.
- Moves are sampled at exactly one edge. Consumers read them while `play` is high or at any later time.
- Press and release never trigger in the same cycle; the FSM processes at most one transition per cycle.

## Structure
- Shared package `rps_pkg`:
  - move encodings ROCK=2'b00, SCISSOR=2'b01, PAPER=2'b10, MOVE_INVALID=2'b11;
  - state enum {IDLE, HOLD};
  - score width 8.
- Sub-module `debouncer`: clock, reset, raw in, parameter `DEBOUNCE_CYCLES`; outputs `stable`, `rise`, `fall`. It contains the two-flop sync and the counter.
- `round_sequencer` holds the FSM, capture registers and round counter.

## Test plan
All scenarios use D=4.
- Clean press, `user_sw`=01, `com_choice`=10 at capture edge, high for 20 cycles -> one `play` pulse after edge 7; `user_move`=01; `com_move`=10; `round_count`=1; `busy` high until 7 edges after release.
- Bounce: `load_sw` toggles 1,0,1,0 at 2-cycle spacing, then held high -> exactly one `play`, timed from the start of the final steady high; 3-cycle glitches while idle -> no strobe.
- Invalid: `user_sw`=11, press -> `invalid` for 1 cycle; `play`=0; `round_count` unchanged; `user_move`=11.
- Re-trigger: hold high 100 cycles, then `user_sw` changes -> no second strobe; after release and a new press -> second `play`, new moves latched.
- Wrap: 256 valid presses -> `round_count` returns to 0; exactly 256 `play` pulses.
- Reset mid-HOLD with switch held high -> outputs zero on the next edge; after reset release, one new `play` D+3 edges later; `round_count`=1.

Source files
------------

// File: rtl/rps_pkg.sv
// rps_pkg: shared definitions for the rock-paper-scissors datapath.
//   Move encodings, FSM state type and score/counter width.
package rps_pkg;
  localparam logic [1:0] ROCK         = 2'b00;
  localparam logic [1:0] SCISSOR      = 2'b01;
  localparam logic [1:0] PAPER        = 2'b10;
  localparam logic [1:0] MOVE_INVALID = 2'b11;

  localparam int SCORE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/debouncer.sv
// debouncer: two-flop synchronizer plus counter debounce for one raw switch.
//   clock  : rising-edge clock
//   reset  : synchronous, active-low
//   raw    : asynchronous switch input
//   stable : debounced level
//   rise   : stable went 0->1 at the last edge (one cycle)
//   fall   : stable went 1->0 at the last edge (one cycle)
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             r_stable;
  logic             r_stable_d;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;

  assign w_diff = r_sync[1] ^ r_stable;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sync     <= '0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync     <= {r_sync[0], raw};
      r_stable_d <= r_stable;
      // Any agreement with the stable level restarts the run, so only an
      // uninterrupted run of DEBOUNCE_CYCLES differing samples flips it.
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_CNT_MAX) begin
        r_stable <= ~r_stable;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign stable = r_stable;
  assign rise   = r_stable & ~r_stable_d;
  assign fall   = ~r_stable & r_stable_d;
endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: turns a bouncing load switch into one clean round per press.
//   clock       : rising-edge clock
//   reset       : synchronous, active-low; clears all state
//   load_sw     : raw load switch
//   user_sw     : user move (quasi-static, sampled at capture)
//   com_choice  : free-running computer move
//   play        : one-cycle strobe, captured moves form a valid round
//   invalid     : one-cycle strobe, press rejected (user move 11)
//   user_move   : user move latched at round start
//   com_move    : computer move latched at round start
//   round_count : valid rounds modulo 256
//   busy        : high while the press is held (HOLD)
module round_sequencer
  import rps_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_sw,
  input  logic [1:0]         user_sw,
  input  logic [1:0]         com_choice,
  output logic               play,
  output logic               invalid,
  output logic [1:0]         user_move,
  output logic [1:0]         com_move,
  output logic [SCORE_W-1:0] round_count,
  output logic               busy
);
  logic               w_stable;
  logic               w_rise;
  logic               w_fall;
  state_t             r_state;
  state_t             w_next;
  logic               w_capture;
  logic               r_play;
  logic               r_invalid;
  logic [1:0]         r_user_move;
  logic [1:0]         r_com_move;
  logic [SCORE_W-1:0] r_round_count;

  debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb (
    .clock  (clock),
    .reset  (reset),
    .raw    (load_sw),
    .stable (w_stable),
    .rise   (w_rise),
    .fall   (w_fall)
  );

  always_ff @(posedge clock) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // rise cannot occur in HOLD (stable is already high), so it is only
  // examined in IDLE; likewise fall only matters in HOLD.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      IDLE: if (w_rise) begin
        w_next    = HOLD;
        w_capture = 1'b1;
      end
      HOLD: if (w_fall) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_play        <= 1'b0;
      r_invalid     <= 1'b0;
      r_user_move   <= '0;
      r_com_move    <= '0;
      r_round_count <= '0;
    end else begin
      r_play    <= 1'b0;
      r_invalid <= 1'b0;
      if (w_capture) begin
        r_user_move <= user_sw;
        r_com_move  <= com_choice;
        if (user_sw != MOVE_INVALID) begin
          r_play        <= 1'b1;
          r_round_count <= r_round_count + 1'b1;
        end else begin
          r_invalid <= 1'b1;
        end
      end
    end
  end

  assign play        = r_play;
  assign invalid     = r_invalid;
  assign user_move   = r_user_move;
  assign com_move    = r_com_move;
  assign round_count = r_round_count;
  assign busy        = (r_state == HOLD);
endmodule

// File: tb/tb_round_sequencer.sv
module tb_round_sequencer;
  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load_sw = 1'b0;
  logic [1:0] user_sw = 2'b00;
  logic [1:0] com_choice = 2'b00;
  logic       play, invalid, busy;
  logic [1:0] user_move, com_move;
  logic [7:0] round_count;

  round_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
    .clock       (clock),
    .reset       (reset),
    .load_sw     (load_sw),
    .user_sw     (user_sw),
    .com_choice  (com_choice),
    .play        (play),
    .invalid     (invalid),
    .user_move   (user_move),
    .com_move    (com_move),
    .round_count (round_count),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic       is_play;
    logic [1:0] um;
    logic [1:0] cm;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         n_fail = 0;
  int         n_play_seen = 0;
  logic [7:0] exp_cnt = 8'd0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Called right after the edge at which load_sw (or reset release) is
  // first presented; the strobe is due D+3 edges later.
  task automatic expect_round(input logic [1:0] um, input logic [1:0] cm);
    exp_t e;
    e.cyc     = cyc + D + 3;
    e.is_play = (um != 2'b11);
    e.um      = um;
    e.cm      = cm;
    if (e.is_play) exp_cnt = exp_cnt + 8'd1;
    e.cnt     = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic press(input logic [1:0] um, input logic [1:0] cm, input int hold, input int gap);
    user_sw    = um;
    com_choice = cm;
    load_sw    = 1'b1;
    expect_round(um, cm);
    tick(hold);
    load_sw = 1'b0;
    tick(gap);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_play"}, play, 0);
    check({tag, "_invalid"}, invalid, 0);
    check({tag, "_user_move"}, user_move, 0);
    check({tag, "_com_move"}, com_move, 0);
    check({tag, "_round_count"}, round_count, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Scoreboard monitor: every strobe cycle must match the head entry.
  always @(negedge clock) begin
    exp_t e;
    if (play === 1'b1 || invalid === 1'b1) begin
      if (play === 1'b1) n_play_seen++;
      check("strobe_exclusive", play & invalid, 0);
      check("strobe_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("strobe_play", play, e.is_play);
        check("strobe_invalid", invalid, !e.is_play);
        check("strobe_user_move", user_move, e.um);
        check("strobe_com_move", com_move, e.cm);
        check("strobe_round_count", round_count, e.cnt);
      end
    end
  end

  initial begin
    int plays0;

    // Reset state
    tick(3);
    check_zero("reset");
    reset = 1'b1;
    tick(2);

    // Clean press with explicit latency and busy timing
    user_sw = 2'b01; com_choice = 2'b10; load_sw = 1'b1;
    expect_round(2'b01, 2'b10);
    tick(6);
    check("clean_busy_early", busy, 0);
    tick(1);
    check("clean_busy_rise", busy, 1);
    check("clean_user_move", user_move, 2'b01);
    tick(13);
    load_sw = 1'b0;
    tick(6);
    check("clean_busy_hold", busy, 1);
    tick(1);
    check("clean_busy_fall", busy, 0);
    check("clean_round_count", round_count, 1);
    tick(5);

    // Bounce then steady high: one round from the final rising step
    user_sw = 2'b10; com_choice = 2'b00;
    load_sw = 1'b1; tick(2); load_sw = 1'b0; tick(2);
    load_sw = 1'b1; tick(2); load_sw = 1'b0; tick(2);
    load_sw = 1'b1;
    expect_round(2'b10, 2'b00);
    tick(20);
    load_sw = 1'b0;
    tick(12);

    // Short glitches while idle never produce a strobe
    load_sw = 1'b1; tick(3); load_sw = 1'b0; tick(12);
    load_sw = 1'b1; tick(3); load_sw = 1'b0; tick(12);
    check("glitch_busy", busy, 0);
    check("glitch_round_count", round_count, exp_cnt);

    // Invalid move
    press(2'b11, 2'b01, 20, 12);
    check("invalid_round_count", round_count, 2);
    check("invalid_user_move", user_move, 2'b11);

    // Re-trigger blocked while held, new moves ignored until next capture
    user_sw = 2'b00; com_choice = 2'b01; load_sw = 1'b1;
    expect_round(2'b00, 2'b01);
    tick(50);
    user_sw = 2'b01; com_choice = 2'b10;
    tick(50);
    check("retrig_user_hold", user_move, 2'b00);
    check("retrig_com_hold", com_move, 2'b01);
    load_sw = 1'b0;
    tick(12);
    press(2'b01, 2'b10, 20, 12);
    check("retrig_user_new", user_move, 2'b01);
    check("retrig_com_new", com_move, 2'b10);
    check("retrig_round_count", round_count, 4);

    // Wrap: from reset, 256 valid rounds bring the counter back to 0
    reset = 1'b0; tick(2); reset = 1'b1; tick(2);
    exp_cnt = 8'd0;
    check("wrap_start", round_count, 0);
    plays0 = n_play_seen;
    for (int i = 0; i < 256; i++)
      press(2'(i % 3), 2'((i + 1) % 3), 10, 10);
    check("wrap_round_count", round_count, 0);
    check("wrap_play_pulses", n_play_seen - plays0, 256);

    // Reset in HOLD with the switch held; one new round after release
    user_sw = 2'b10; com_choice = 2'b01; load_sw = 1'b1;
    expect_round(2'b10, 2'b01);
    tick(20);
    check("midhold_busy", busy, 1);
    reset = 1'b0;
    tick(1);
    check_zero("midhold_reset");
    tick(2);
    exp_cnt = 8'd0;
    reset = 1'b1;
    expect_round(2'b10, 2'b01);
    tick(20);
    check("midhold_round_count", round_count, 1);
    check("midhold_busy_again", busy, 1);
    load_sw = 1'b0;
    tick(12);

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
